// File: rtl/rt_pkg.sv
// Shared widths, FSM states and configuration record for the ray-tracing frame sequencer.
package rt_pkg;
    localparam int COORD_W = 8;
    localparam int COLOR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN
    } seq_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos_x;
        logic [COORD_W-1:0] pos_y;
        logic [COORD_W-1:0] pos_z;
        logic [COORD_W-1:0] dir_x;
        logic [COORD_W-1:0] dir_y;
        logic [COORD_W-1:0] dir_z;
        logic [COORD_W-1:0] distance;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
    } cam_cfg_t;
endpackage

// File: rtl/raster_counter.sv
// Raster-order pixel counter: walks x across a line, then steps y; flags first pixel,
// end of line and final pixel of the frame for the current position.
module raster_counter #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               first,
    output logic               eol,
    output logic               last
);
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (eol) begin
                x_d = '0;
                y_d = last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign first = (x_q == '0) && (y_q == '0);
    assign eol   = (x_q == width - 1'b1);
    assign last  = eol && (y_q == height - 1'b1);
endmodule

// File: rtl/frame_sequencer.sv
// Frame scheduler for the RTU: latches and validates the camera/image config, issues one ray per
// pixel in raster order with a bounded in-flight window, and tags returned pixels with SOF/EOL.
module frame_sequencer #(
    parameter int COORD_W      = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int COLOR_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [COORD_W-1:0] image_width,
    input  logic [COORD_W-1:0] image_height,
    input  logic [COORD_W-1:0] camera_pos_x,
    input  logic [COORD_W-1:0] camera_pos_y,
    input  logic [COORD_W-1:0] camera_pos_z,
    input  logic [COORD_W-1:0] camera_dir_x,
    input  logic [COORD_W-1:0] camera_dir_y,
    input  logic [COORD_W-1:0] camera_dir_z,
    input  logic [COORD_W-1:0] camera_distance,
    output logic               busy,
    output logic               error,
    output logic               frame_done,
    output logic [COORD_W-1:0] cfg_image_width,
    output logic [COORD_W-1:0] cfg_image_height,
    output logic [COORD_W-1:0] cfg_camera_pos_x,
    output logic [COORD_W-1:0] cfg_camera_pos_y,
    output logic [COORD_W-1:0] cfg_camera_pos_z,
    output logic [COORD_W-1:0] cfg_camera_dir_x,
    output logic [COORD_W-1:0] cfg_camera_dir_y,
    output logic [COORD_W-1:0] cfg_camera_dir_z,
    output logic [COORD_W-1:0] cfg_camera_distance,
    output logic               ray_valid,
    input  logic               ray_ready,
    output logic [COORD_W-1:0] ray_x,
    output logic [COORD_W-1:0] ray_y,
    input  logic               px_valid,
    output logic               px_ready,
    input  logic [COLOR_W-1:0] px_r,
    input  logic [COLOR_W-1:0] px_g,
    input  logic [COLOR_W-1:0] px_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eol,
    output logic [COLOR_W-1:0] out_r,
    output logic [COLOR_W-1:0] out_g,
    output logic [COLOR_W-1:0] out_b
);
    import rt_pkg::*;

    // Wide enough for MAX_INFLIGHT up to 15.
    localparam int IFW = 4;

    seq_state_t     state_q, state_d;
    cam_cfg_t       cfg_q, cfg_d;
    logic           error_q, error_d;
    logic [IFW-1:0] inflight_q, inflight_d;

    logic active, issue, ret, ctr_clear, cfg_zero;
    logic iss_last, ret_first, ret_eol, ret_last;
    logic iss_unused_first, iss_unused_eol;
    logic [COORD_W-1:0] ret_unused_x, ret_unused_y;

    assign active   = (state_q == RUN) || (state_q == DRAIN);
    assign ray_valid = (state_q == RUN) && (inflight_q < IFW'(MAX_INFLIGHT));
    assign issue    = ray_valid && ray_ready;
    assign px_ready = out_ready && active;
    assign out_valid = px_valid && active;
    assign ret      = px_valid && px_ready;
    assign cfg_zero = (cfg_q.width == '0) || (cfg_q.height == '0) || (cfg_q.distance == '0);

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        error_d   = error_q;
        ctr_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    cfg_d = '{pos_x: camera_pos_x, pos_y: camera_pos_y, pos_z: camera_pos_z,
                              dir_x: camera_dir_x, dir_y: camera_dir_y, dir_z: camera_dir_z,
                              distance: camera_distance, width: image_width,
                              height: image_height};
                    error_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cfg_zero) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    ctr_clear = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (ret && ret_last) begin
                    state_d = IDLE;
                end else if (issue && iss_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ret && ret_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous issue and return cancel out; the issue gate keeps this within MAX_INFLIGHT.
    always_comb begin
        inflight_d = ctr_clear ? '0 : inflight_q + IFW'(issue) - IFW'(ret);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            error_q    <= 1'b0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            error_q    <= error_d;
            inflight_q <= inflight_d;
        end
    end

    raster_counter #(.COORD_W(COORD_W)) u_issue_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .advance (issue),
        .width   (cfg_q.width),
        .height  (cfg_q.height),
        .x       (ray_x),
        .y       (ray_y),
        .first   (iss_unused_first),
        .eol     (iss_unused_eol),
        .last    (iss_last)
    );

    raster_counter #(.COORD_W(COORD_W)) u_return_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .advance (ret),
        .width   (cfg_q.width),
        .height  (cfg_q.height),
        .x       (ret_unused_x),
        .y       (ret_unused_y),
        .first   (ret_first),
        .eol     (ret_eol),
        .last    (ret_last)
    );

    assign busy       = (state_q != IDLE);
    assign error      = error_q;
    assign frame_done = ret && ret_last;
    assign out_sof    = out_valid && ret_first;
    assign out_eol    = out_valid && ret_eol;
    assign out_r      = px_r;
    assign out_g      = px_g;
    assign out_b      = px_b;

    assign cfg_image_width     = cfg_q.width;
    assign cfg_image_height    = cfg_q.height;
    assign cfg_camera_pos_x    = cfg_q.pos_x;
    assign cfg_camera_pos_y    = cfg_q.pos_y;
    assign cfg_camera_pos_z    = cfg_q.pos_z;
    assign cfg_camera_dir_x    = cfg_q.dir_x;
    assign cfg_camera_dir_y    = cfg_q.dir_y;
    assign cfg_camera_dir_z    = cfg_q.dir_z;
    assign cfg_camera_distance = cfg_q.distance;
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a queue-based RTU model with random latency and stalls,
// expected raster sequences built per frame, and a monitor that checks every handshake.
module tb_frame_sequencer;
    localparam int MAXI = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_start = 1'b0;
    logic [7:0] image_width = '0, image_height = '0, camera_distance = '0;
    logic [7:0] camera_pos_x = '0, camera_pos_y = '0, camera_pos_z = '0;
    logic [7:0] camera_dir_x = '0, camera_dir_y = '0, camera_dir_z = '0;
    logic       busy, error, frame_done;
    logic [7:0] cfg_image_width, cfg_image_height, cfg_camera_distance;
    logic [7:0] cfg_camera_pos_x, cfg_camera_pos_y, cfg_camera_pos_z;
    logic [7:0] cfg_camera_dir_x, cfg_camera_dir_y, cfg_camera_dir_z;
    logic       ray_valid, ray_ready = 1'b0;
    logic [7:0] ray_x, ray_y;
    logic       px_valid = 1'b0, px_ready;
    logic [7:0] px_r = '0, px_g = '0, px_b = '0;
    logic       out_valid, out_ready = 1'b0, out_sof, out_eol;
    logic [7:0] out_r, out_g, out_b;

    always #5 clk = ~clk;

    frame_sequencer #(.COORD_W(8), .MAX_INFLIGHT(MAXI), .COLOR_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start),
        .image_width(image_width), .image_height(image_height),
        .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
        .camera_dir_x(camera_dir_x), .camera_dir_y(camera_dir_y), .camera_dir_z(camera_dir_z),
        .camera_distance(camera_distance),
        .busy(busy), .error(error), .frame_done(frame_done),
        .cfg_image_width(cfg_image_width), .cfg_image_height(cfg_image_height),
        .cfg_camera_pos_x(cfg_camera_pos_x), .cfg_camera_pos_y(cfg_camera_pos_y),
        .cfg_camera_pos_z(cfg_camera_pos_z), .cfg_camera_dir_x(cfg_camera_dir_x),
        .cfg_camera_dir_y(cfg_camera_dir_y), .cfg_camera_dir_z(cfg_camera_dir_z),
        .cfg_camera_distance(cfg_camera_distance),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_x(ray_x), .ray_y(ray_y),
        .px_valid(px_valid), .px_ready(px_ready), .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .out_r(out_r), .out_g(out_g), .out_b(out_b)
    );

    typedef struct { int x; int y; int t; } rtu_t;
    typedef struct { int x; int y; bit sof; bit eol; bit last; } pix_t;

    rtu_t rtu_q[$];
    pix_t exp_iss[$];
    pix_t exp_out[$];
    pix_t mp;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int rr_mode = 0, or_mode = 0, lat_min = 3, lat_max = 3;
    int rel_budget = 1000000, iss_limit = 1000000;
    int issues = 0, returns = 0, outstanding = 0, done_cnt = 0, rv_cycles = 0, salt = 0;
    int sv_w = 0, sv_h = 0, sv_px = 0, sv_dz = 0, sv_d = 0;
    bit px_force = 1'b0, prev_pend = 1'b0;
    logic [7:0] prev_x = '0, prev_y = '0;

    function automatic logic [7:0] col(input int x, input int y, input int s, input int c);
        return 8'((x * 13 + y * 29 + s * 7 + c * 71) % 256);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // RTU and downstream model: drives readies and in-order results just after each edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) begin
            ray_ready = 1'b0;
            out_ready = 1'b0;
            px_valid  = 1'b0;
        end else begin
            ray_ready = (issues < iss_limit) &&
                        ((rr_mode == 0) || ((rr_mode == 1) && ($urandom_range(0, 2) != 0)));
            out_ready = (or_mode == 0) || ($urandom_range(0, 2) != 0);
            px_r = 8'($urandom);
            px_g = 8'($urandom);
            px_b = 8'($urandom);
            px_valid = px_force;
            if (rtu_q.size() > 0 && rel_budget > 0 && rtu_q[0].t <= cyc) begin
                px_valid = 1'b1;
                px_r = col(rtu_q[0].x, rtu_q[0].y, salt, 0);
                px_g = col(rtu_q[0].x, rtu_q[0].y, salt, 1);
                px_b = col(rtu_q[0].x, rtu_q[0].y, salt, 2);
            end
        end
    end

    // Monitor: sampled mid-cycle, when all inputs and combinational outputs are settled.
    always @(negedge clk) begin
        if (reset) begin
            prev_pend = 1'b0;
        end else begin
            if (ray_valid) rv_cycles++;
            if (prev_pend) begin
                chk("ray_hold_valid", int'(ray_valid), 1);
                chk("ray_hold_xy", int'({ray_x, ray_y}), int'({prev_x, prev_y}));
            end
            prev_pend = ray_valid && !ray_ready;
            prev_x = ray_x;
            prev_y = ray_y;
            if (ray_valid && ray_ready) begin
                issues++;
                outstanding++;
                chk("inflight_bound", int'(outstanding <= MAXI), 1);
                if (exp_iss.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ray_unexpected: got (%0d,%0d), required no request", ray_x, ray_y);
                end else begin
                    mp = exp_iss.pop_front();
                    chk("ray_x", int'(ray_x), mp.x);
                    chk("ray_y", int'(ray_y), mp.y);
                end
                rtu_q.push_back('{x: int'(ray_x), y: int'(ray_y),
                                  t: cyc + int'($urandom_range(lat_min, lat_max))});
            end
            if (px_valid && px_ready && rtu_q.size() > 0) begin
                rtu_q.delete(0);
                returns++;
                outstanding--;
                if (rel_budget > 0) rel_budget--;
                chk("inflight_floor", int'(outstanding >= 0), 1);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got r=%0d, required no beat", out_r);
                end else begin
                    mp = exp_out.pop_front();
                    chk("out_r", int'(out_r), int'(col(mp.x, mp.y, salt, 0)));
                    chk("out_g", int'(out_g), int'(col(mp.x, mp.y, salt, 1)));
                    chk("out_b", int'(out_b), int'(col(mp.x, mp.y, salt, 2)));
                    chk("out_sof", int'(out_sof), int'(mp.sof));
                    chk("out_eol", int'(out_eol), int'(mp.eol));
                    chk("frame_done_on_beat", int'(frame_done), int'(mp.last));
                end
                if (frame_done) done_cnt++;
            end else if (frame_done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL frame_done_stray: got 1 without an accepted beat, required 0");
            end
        end
    end

    task automatic scramble_inputs();
        image_width = 8'($urandom);    image_height = 8'($urandom);
        camera_distance = 8'($urandom);
        camera_pos_x = 8'($urandom);   camera_pos_y = 8'($urandom);  camera_pos_z = 8'($urandom);
        camera_dir_x = 8'($urandom);   camera_dir_y = 8'($urandom);  camera_dir_z = 8'($urandom);
    endtask

    task automatic start(input int w, input int h, input int d);
        bit ok;
        ok = (w != 0) && (h != 0) && (d != 0);
        @(posedge clk); #1;
        exp_iss.delete();
        exp_out.delete();
        if (ok) begin
            for (int yy = 0; yy < h; yy++)
                for (int xx = 0; xx < w; xx++)
                    exp_iss.push_back('{x: xx, y: yy, sof: (xx == 0 && yy == 0), eol: (xx == w - 1),
                                        last: (xx == w - 1 && yy == h - 1)});
        end
        exp_out = exp_iss;
        issues = 0; returns = 0; outstanding = 0; done_cnt = 0;
        salt = int'($urandom_range(0, 255));
        sv_w = w; sv_h = h; sv_d = d;
        sv_px = int'($urandom_range(0, 255));
        sv_dz = int'($urandom_range(0, 255));
        scramble_inputs();
        image_width = 8'(w); image_height = 8'(h); camera_distance = 8'(d);
        camera_pos_x = 8'(sv_px); camera_dir_z = 8'(sv_dz);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        chk("busy_in_check", int'(busy), 1);
        chk("ray_valid_in_check", int'(ray_valid), 0);
        chk("error_cleared", int'(error), 0);
        @(negedge clk);
        if (ok) begin
            chk("first_ray_latency", int'(ray_valid), 1);
            chk("cfg_width", int'(cfg_image_width), w);
            chk("cfg_height", int'(cfg_image_height), h);
            chk("cfg_distance", int'(cfg_camera_distance), d);
            chk("cfg_pos_x", int'(cfg_camera_pos_x), sv_px);
        end else begin
            chk("error_set", int'(error), 1);
            chk("busy_after_error", int'(busy), 0);
        end
    endtask

    task automatic finish_frame(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, required one", limit);
        end
        @(negedge clk);
        chk("frame_done_count", done_cnt, 1);
        chk("rays_issued", issues, sv_w * sv_h);
        chk("rays_left", exp_iss.size(), 0);
        chk("beats_left", exp_out.size(), 0);
        chk("busy_after_frame", int'(busy), 0);
        chk("cfg_width_held", int'(cfg_image_width), sv_w);
        chk("cfg_distance_held", int'(cfg_camera_distance), sv_d);
        chk("cfg_dir_z_held", int'(cfg_camera_dir_z), sv_dz);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rv0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_ray_valid", int'(ray_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_px_ready", int'(px_ready), 0);
        chk("rst_cfg_width", int'(cfg_image_width), 0);
        chk("rst_cfg_distance", int'(cfg_camera_distance), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic 4x2 frame, always ready, fixed RTU latency.
        start(4, 2, 5);
        finish_frame(400);

        // Zero width, height or distance each raise error without issuing rays.
        rv0 = rv_cycles;
        start(0, 2, 5);
        start(3, 0, 5);
        start(3, 2, 0);
        idle_cycles(3);
        chk("no_ray_on_error", rv_cycles, rv0);
        start(2, 2, 1);
        finish_frame(400);

        // RTU holds all results: window fills, then one release admits exactly one more ray.
        rel_budget = 0;
        start(4, 4, 3);
        idle_cycles(20);
        chk("window_full_issues", issues, MAXI);
        chk("window_full_valid", int'(ray_valid), 0);
        rel_budget = 1;
        idle_cycles(20);
        chk("one_release_issues", issues, MAXI + 1);
        chk("one_release_returns", returns, 1);
        chk("one_release_valid", int'(ray_valid), 0);
        rel_budget = 1000000;
        finish_frame(400);

        // Random stalls on both sides and random RTU latency.
        rr_mode = 1; or_mode = 1; lat_min = 1; lat_max = 5;
        for (int i = 0; i < 4; i++) begin
            start((i == 0) ? 3 : int'($urandom_range(1, 5)), (i == 0) ? 3 : int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 255)));
            finish_frame(600);
        end
        rr_mode = 0; or_mode = 0; lat_min = 2; lat_max = 2;

        // Single-pixel frame.
        start(1, 1, 9);
        finish_frame(100);

        // A result presented while idle is neither accepted nor forwarded.
        @(negedge clk);
        px_force = 1'b1;
        @(negedge clk);
        chk("px_ready_idle", int'(px_ready), 0);
        chk("out_valid_idle", int'(out_valid), 0);
        px_force = 1'b0;

        // Reset mid-frame with three rays outstanding.
        rel_budget = 0; iss_limit = 3;
        start(4, 4, 2);
        idle_cycles(15);
        chk("pre_reset_issues", issues, 3);
        @(posedge clk); #1;
        reset = 1'b1;
        rtu_q.delete();
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ray_valid", int'(ray_valid), 0);
        chk("abort_cfg_width", int'(cfg_image_width), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        iss_limit = 1000000;

        // Fresh frame after abort: a full window proves the in-flight count restarted at zero.
        start(3, 2, 4);
        idle_cycles(15);
        chk("post_reset_window", issues, MAXI);
        @(posedge clk); #1;
        image_width = 8'd7; image_height = 8'd7; camera_distance = 8'd0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("busy_start_ignored", int'(busy), 1);
        chk("cfg_width_unchanged", int'(cfg_image_width), 3);
        chk("error_start_ignored", int'(error), 0);
        rel_budget = 1000000;
        finish_frame(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
